mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port memory of the multicycle RV64 core between the instruction-fetch requester (driven by the control FSM during busca/salvaInstrucao) and the data requester (ld/sd states).
- Serialises accesses, sequences the fixed-latency memory timing, and returns completion pulses and read data to the winning requester.
- Sits between the control unit / datapath and the memory macro.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; fetch uses the low 32 bits.
- MEM_LAT, 1, cycles from address presentation to valid mem_rdata; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched word, registered.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store (sd), 0 = load (ld).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data, registered.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction in flight (state ≠ IDLE).
- owner  out  1  0 = fetch, 1 = data; last or current grant.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, last-grant=data (so fetch wins the first tie).
  - All outputs 0: mem_addr, mem_wdata, mem_we, if_done, d_done, if_rdata, d_rdata, busy, owner.
  - Reset mid-transaction aborts it immediately. No done pulse is issued. A store already strobed is not undone.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - With no request, stay.
  - With exactly one request, grant it.
  - With both requests, grant the port not granted last (round-robin).
  - On grant, at the clock edge:
    - Latch address, wdata and we; fetch forces we=0.
    - Set owner.
    - Load counter = MEM_LAT−1.
    - Go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched values for the whole state.
  - mem_we=1 only in the first ACCESS cycle of a store, and only for that one cycle.
  - Counter decrements each cycle. When counter=0:
    - Capture mem_rdata into the owner's rdata register (loads and fetches only).
    - Go to RESP.
- RESP:
  - Owner's done=1 for exactly one cycle, then go to IDLE.
  - mem_addr holds its value; mem_we=0.
- Latency: done is high during cycle MEM_LAT+1 after the grant edge.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Requester rule: a registered requester samples done and deasserts req on the same edge the arbiter returns to IDLE.
  - A req still high in IDLE is treated as a new transaction.
- Request changes after grant are ignored until IDLE:
  - req dropping mid-transaction still completes the access and pulses done.
  - Address or data changes do not affect the latched transaction.
- A non-owner request stays pending through ACCESS and RESP. It is granted in the next IDLE, or loses a tie per round-robin.
- rdata registers hold their value until the next read completion for their port. A store leaves d_rdata unchanged.
- if_done and d_done are never high in the same cycle.
- mem_we is never high outside ACCESS.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 for 3 cycles, release, no requests for 5 cycles.
  - Required: all outputs 0, busy=0, mem_we never high.
- Single fetch, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=0x100, memory returns 0x00500093 one cycle after address.
  - Required: mem_addr=0x100 in ACCESS; if_done high in cycle 2 after grant edge; if_rdata=0x00500093; d_done stays 0.
- Store then load, MEM_LAT=3:
  - Stimulus: d_req with d_we=1, d_addr=0x200, d_wdata=0xDEADBEEFCAFEF00D; then d_req with d_we=0 at 0x200.
  - Required: mem_we high exactly one cycle; first d_done in cycle 4 after grant; second d_done in cycle 4 after its grant; d_rdata=0xDEADBEEFCAFEF00D.
- Simultaneous requests after reset:
  - Stimulus: if_req and d_req rise together and stay high until their own done.
  - Required: fetch served first (owner=0), then data (owner=1); done pulses never overlap.
- Contention with fetch last served:
  - Stimulus: data request arrives during a fetch, then a new fetch request is raised in the same IDLE cycle as the pending data request.
  - Required: data wins the tie; the pending request is never lost.
- Reset mid-ACCESS, MEM_LAT=3:
  - Stimulus: reset=0 in the second ACCESS cycle of a load.
  - Required: immediate return to IDLE with all outputs 0; no d_done; after release a fresh d_req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// sequencing a fixed-latency access and returning done pulses and read data.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_any;
    logic              grant_d;

    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_any = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    if (if_req && d_req) grant_d = ~last_grant;
                    else                 grant_d = d_req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                addr_q     <= grant_d ? d_addr : if_addr;
                wdata_q    <= grant_d ? d_wdata : '0;
                we_q       <= grant_d & d_we;
                owner      <= grant_d;
                last_grant <= grant_d;
                cnt        <= LAT_M1;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS && cnt == 4'd0 && !we_q) begin
                if (owner) d_rdata  <= mem_rdata;
                else       if_rdata <= mem_rdata;
            end
        end
    end

    // The write strobe is confined to the first ACCESS cycle, where cnt is still at its load value.
    assign mem_we    = (state == ACCESS) && we_q && (cnt == LAT_M1);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);
    assign if_done   = (state == RESP) && !owner;
    assign d_done    = (state == RESP) && owner;

endmodule
